// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: loader state encoding, word width and instruction formats.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package instruction_loader_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CHECK = 3'd6
`endif
    } loader_state_t;

    // Instruction formats: opcode always occupies [31:26].
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [10:0] funct;
    } r_fmt_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } i_fmt_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [20:0] k;
    } k_fmt_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [25:0] target;
    } j_fmt_t;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Counts accepted stream bytes and assembles them MSB-first into 32-bit words.
// word/word_complete are valid in the same cycle the fourth byte is accepted.
module loader_byte_packer
    import instruction_loader_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               accept,
    input  logic [7:0]         in_byte,
    output logic [INSTR_W-1:0] word,
    output logic               word_complete
);

    logic [1:0]  byte_count;
    logic [23:0] shift_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_count <= 2'd0;
            shift_q    <= 24'd0;
        end else if (clear) begin
            byte_count <= 2'd0;
        end else if (accept) begin
            byte_count <= byte_count + 2'd1;
            shift_q    <= {shift_q[15:0], in_byte};
        end
    end

    // The fourth byte is taken straight from the input so the word is ready on its acceptance edge.
    assign word          = {shift_q, in_byte};
    assign word_complete = accept && (byte_count == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed program byte stream into instruction memory while holding the CPU.
// Optional trailing XOR checksum word is enabled by defining LOADER_CHECKSUM_EN.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH  = 31,
    parameter int ADDR_W = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         inByte,
    input  logic               inValid,
    output logic               inReady,
    output logic [ADDR_W-1:0]  writeAddy,
    output logic [INSTR_W-1:0] writeData,
    output logic               writeEnable,
    output logic               cpuHold,
    output logic               done,
    output logic               error
);

    loader_state_t      state, next_state;
    logic [INSTR_W-1:0] length_q;
    logic [ADDR_W-1:0]  word_idx;
    logic [INSTR_W-1:0] word;
    logic               word_complete;
    logic               accept;
    logic               clear_counters;
    logic               last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] checksum_q;
`endif

    assign accept         = inValid && inReady;
    assign clear_counters = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign last_word      = (INSTR_W'(word_idx) + INSTR_W'(1)) >= length_q;

    loader_byte_packer u_packer (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear_counters),
        .accept        (accept),
        .in_byte       (inByte),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // NOTE: every output and next_state gets a default first, so no path through the case infers a latch.
    always_comb begin
        next_state  = state;
        inReady     = 1'b0;
        writeEnable = 1'b0;
        cpuHold     = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_LEN;
            end
            ST_LEN: begin
                inReady = 1'b1;
                if (word_complete) begin
                    if (word == '0)
`ifdef LOADER_CHECKSUM_EN
                        next_state = ST_CHECK;
`else
                        next_state = ST_DONE;
`endif
                    else if (word > INSTR_W'(DEPTH))
                        next_state = ST_ERROR;
                    else
                        next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                inReady = 1'b1;
                if (word_complete) next_state = ST_WRITE;
            end
            ST_WRITE: begin
                writeEnable = 1'b1;
                if (!last_word)
                    next_state = ST_LOAD;
                else
`ifdef LOADER_CHECKSUM_EN
                    next_state = ST_CHECK;
`else
                    next_state = ST_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                inReady = 1'b1;
                if (word_complete) next_state = (word == checksum_q) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE: begin
                cpuHold = 1'b0;
                done    = 1'b1;
                if (start) next_state = ST_LEN;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (start) next_state = ST_LEN;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Write address/data are captured on the fourth data byte and hold until the next word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            length_q   <= '0;
            word_idx   <= '0;
            writeAddy  <= '0;
            writeData  <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            if (clear_counters) begin
                length_q   <= '0;
                word_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
                checksum_q <= '0;
`endif
            end
            if (state == ST_LEN && word_complete) length_q <= word;
            if (state == ST_LOAD && word_complete) begin
                writeAddy  <= word_idx;
                writeData  <= word;
`ifdef LOADER_CHECKSUM_EN
                checksum_q <= checksum_q ^ word;
`endif
            end
            if (state == ST_WRITE) word_idx <= word_idx + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader; checksum steps are active when LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  inByte;
    logic        inValid;
    logic        inReady;
    logic [9:0]  writeAddy;
    logic [31:0] writeData;
    logic        writeEnable;
    logic        cpuHold;
    logic        done;
    logic        error;

    int tests    = 0;
    int failures = 0;

    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic        we_prev     = 1'b0;
    int          we_repeated = 0;

    instruction_loader #(.DEPTH(31), .ADDR_W(10)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .inByte      (inByte),
        .inValid     (inValid),
        .inReady     (inReady),
        .writeAddy   (writeAddy),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .cpuHold     (cpuHold),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    // Write monitor samples on the falling edge; the stimulus acts 1 time unit later.
    always @(negedge clock) begin
        if (writeEnable) begin
            wr_addr_q.push_back(writeAddy);
            wr_data_q.push_back(writeData);
            if (we_prev) we_repeated++;
        end
        we_prev = writeEnable;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        inByte  = b;
        inValid = 1'b1;
        n = 0;
        while (!inReady && n < 50) begin
            tick();
            n++;
        end
        check("byte accepted within budget", inReady, 1'b1);
        tick();
        inValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " inReady"},     inReady,     1'b0);
        check({tag, " writeEnable"}, writeEnable, 1'b0);
        check({tag, " writeAddy"},   writeAddy,   10'd0);
        check({tag, " writeData"},   writeData,   32'd0);
        check({tag, " cpuHold"},     cpuHold,     1'b1);
        check({tag, " done"},        done,        1'b0);
        check({tag, " error"},       error,       1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] stream [12];
        stream = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h04, 8'h41, 8'h18, 8'h00, 8'h58, 8'h60, 8'h00, 8'h00};

        reset   = 1'b1;
        start   = 1'b0;
        inByte  = 8'h00;
        inValid = 1'b0;
        #3;
        check_reset_outputs("power-on reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle inReady", inReady, 1'b0);

        // Basic two-word load; start pulsed mid-load must be ignored.
        pulse_start();
        check("LEN inReady", inReady, 1'b1);
        send_word(32'h0000_0002);
        send_word(32'h0441_1800);
        check("write0 strobe one cycle after 4th byte", writeEnable, 1'b1);
        check("write0 addr", writeAddy, 10'd0);
        check("write0 data", writeData, 32'h0441_1800);
        send_byte(8'h58);
        pulse_start();
        send_byte(8'h60);
        send_byte(8'h00);
        send_byte(8'h00);
        check("write1 strobe", writeEnable, 1'b1);
        check("write1 addr", writeAddy, 10'd1);
        check("write1 data", writeData, 32'h5860_0000);
        tick();
`ifdef LOADER_CHECKSUM_EN
        check("CHECK holds cpu", cpuHold, 1'b1);
        send_word(32'h5C21_1800);
`endif
        check("load done", done, 1'b1);
        check("load cpuHold released", cpuHold, 1'b0);
        check("load error clear", error, 1'b0);
        check("DONE inReady", inReady, 1'b0);
        check("writeData holds in DONE", writeData, 32'h5860_0000);
        check("two writes recorded", wr_data_q.size(), 2);

        // Bytes offered in DONE are not consumed.
        inByte  = 8'hAA;
        inValid = 1'b1;
        tick();
        tick();
        tick();
        check("DONE refuses bytes", inReady, 1'b0);
        check("DONE stays done", done, 1'b1);
        inValid = 1'b0;

        // Length above DEPTH aborts with no write.
        base = wr_data_q.size();
        pulse_start();
        check("restart raises cpuHold", cpuHold, 1'b1);
        check("restart clears done", done, 1'b0);
        send_word(32'h0000_0020);
        check("len 32 error", error, 1'b1);
        check("len 32 done low", done, 1'b0);
        check("len 32 inReady", inReady, 1'b0);
        check("len 32 cpuHold", cpuHold, 1'b1);
        tick();
        tick();
        check("len 32 no write", wr_data_q.size(), base);

        // Zero-length program.
        pulse_start();
        check("restart clears error", error, 1'b0);
        send_word(32'h0000_0000);
`ifdef LOADER_CHECKSUM_EN
        check("len 0 waits for checksum", done, 1'b0);
        send_word(32'h0000_0000);
        check("len 0 checksum 0 done", done, 1'b1);
        pulse_start();
        send_word(32'h0000_0000);
        send_word(32'h0000_0001);
        check("len 0 checksum 1 error", error, 1'b1);
`else
        check("len 0 done", done, 1'b1);
        check("len 0 cpuHold", cpuHold, 1'b0);
`endif
        check("len 0 no write", wr_data_q.size(), base);

        // Throttled stream: idle cycle after each byte, except inValid held through WRITE.
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            send_byte(stream[i]);
            if (i != 7) tick();
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h5C21_1800);
`endif
        check("throttled done", done, 1'b1);
        check("throttled write count", wr_data_q.size(), base + 2);
        check("throttled addr0", wr_addr_q[base], 10'd0);
        check("throttled data0", wr_data_q[base], 32'h0441_1800);
        check("throttled addr1", wr_addr_q[base+1], 10'd1);
        check("throttled data1", wr_data_q[base+1], 32'h5860_0000);

        // Asynchronous reset mid-load, then a clean reload from address 0.
        pulse_start();
        send_word(32'h0000_0003);
        send_word(32'h1122_3344);
        check("3-word first write data", writeData, 32'h1122_3344);
        tick();
        send_byte(8'h55);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid-load reset");
        tick();
        reset = 1'b0;
        tick();
        check("post-reset cpuHold", cpuHold, 1'b1);
        base = wr_data_q.size();
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(stream[i]);
        tick();
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h0000_0000);
        check("bad checksum error", error, 1'b1);
        check("bad checksum cpuHold", cpuHold, 1'b1);
        check("bad checksum done low", done, 1'b0);
`else
        check("reload done", done, 1'b1);
`endif
        check("reload addr0", wr_addr_q[base], 10'd0);
        check("reload data0", wr_data_q[base], 32'h0441_1800);
        check("reload data1", wr_data_q[base+1], 32'h5860_0000);
        check("single-cycle write strobes", we_repeated, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter DEPTH, default 31: number of instruction words the target instruction memory holds.
REQ-002 Parameter ADDR_W, default 10: width of the instruction memory write address.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 inByte  input  8  program stream byte.
REQ-007 inValid  input  1  inByte valid.
REQ-008 inReady  output  1  loader can accept a byte; a transfer occurs on a cycle with inValid && inReady.
REQ-009 writeAddy  output  ADDR_W  instruction memory write address.
REQ-010 writeData  output  32  instruction word to write.
REQ-011 writeEnable  output  1  one-cycle write strobe to instruction memory.
REQ-012 cpuHold  output  1  holds the processor PC/fetch while the program is not valid.
REQ-013 done  output  1  program loaded successfully.
REQ-014 error  output  1  load aborted (bad length, or checksum mismatch when enabled).

Function
REQ-015 The FSM SHALL have states IDLE, LEN, LOAD, WRITE, DONE and ERROR, plus CHECK when LOADER_CHECKSUM_EN is defined.
REQ-016 Bytes SHALL be assembled MSB-first: the first accepted byte of a group becomes bits [31:24] and the fourth becomes bits [7:0].
REQ-017 IDLE: inReady=0; start moves the FSM to LEN and clears the byte counter, the word index and the checksum accumulator.
REQ-018 LEN: inReady=1; after 4 bytes the word is latched as the length L.
  - L=0 -> DONE.
  - L>DEPTH -> ERROR.
  - Otherwise -> LOAD.
REQ-019 LOAD: inReady=1; after the 4th byte of a word the FSM SHALL go to WRITE on the next edge.
REQ-020 WRITE lasts exactly one cycle with inReady=0, writeEnable=1, writeAddy=word index (starting at 0) and writeData=the assembled word.
  - Then the word index increments.
  - The FSM returns to LOAD if index<L.
  - Otherwise it goes to DONE (or to CHECK when the checksum is enabled).
REQ-021 writeEnable SHALL be 0 in every state other than WRITE; writeAddy and writeData hold their last value.
REQ-022 Latency from acceptance of a word's 4th byte to its writeEnable SHALL be exactly 1 cycle.
REQ-023 cpuHold SHALL be 1 in every state except DONE.
REQ-024 In DONE: done=1, error=0, inReady=0.
REQ-025 In ERROR: error=1, done=0, inReady=0; no further writes occur.
REQ-026 start SHALL be ignored in LEN, LOAD, WRITE and CHECK.
REQ-027 start in DONE or ERROR SHALL re-enter LEN and clear done, error and all counters; cpuHold rises again in the same cycle the state leaves DONE.
REQ-028 A byte offered while inReady=0 SHALL NOT be consumed.
REQ-029 The word index SHALL never exceed DEPTH-1 on a write, so there is no wrap-around.

Reset
REQ-030 Reset SHALL force, asynchronously:
  - state=IDLE;
  - inReady=0, writeEnable=0, writeAddy=0, writeData=0;
  - cpuHold=1, done=0, error=0;
  - all counters and the checksum accumulator to 0.
REQ-031 Reset asserted mid-load SHALL abandon the load; memory words already written are not rolled back.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN, when defined, SHALL add state CHECK.
  - After the last write, CHECK accepts one further 4-byte word.
  - The FSM goes to DONE if that word equals the XOR of all L data words, else to ERROR.
  - For L=0 the FSM goes from LEN to CHECK, and the expected value is 0.
REQ-033 Without LOADER_CHECKSUM_EN, the CHECK state and the accumulator SHALL NOT exist, and the FSM goes from the last WRITE directly to DONE.

Structure
REQ-034 A shared package SHALL hold:
  - the loader state encoding;
  - the instruction-word width (32);
  - the field layout of R/I/K/J instruction formats: opcode [31:26], rs/rt/rd 5-bit fields, 16-bit immediate, 21-bit K field, 26-bit jump target.
REQ-035 One sub-module, loader_byte_packer, SHALL do the byte counting and MSB-first word assembly, with a word-complete strobe output.

Verification
REQ-036 start; stream 00 00 00 02, 04 41 18 00, 58 60 00 00 -> two single-cycle writes:
  - addr 0 data 32'h04411800;
  - addr 1 data 32'h58600000;
  - then done=1, cpuHold=0.
REQ-037 Header length 32 (DEPTH=31) -> ERROR immediately after the 4th header byte, with no writeEnable pulse.
REQ-038 Header length 0 -> DONE (with the checksum enabled: DONE after checksum word 0, ERROR after checksum word 1).
REQ-039 inValid toggling every other cycle during LOAD, plus inValid held high during a WRITE cycle -> no byte is lost or duplicated, and the written data matches REQ-036.
REQ-040 Reset asserted after the first write of a 3-word load -> outputs take their reset values immediately; a new start then reloads correctly from address 0.
REQ-041 With LOADER_CHECKSUM_EN: REQ-036 stream followed by checksum 5C 21 18 00 -> DONE; checksum 00 00 00 00 -> ERROR with cpuHold=1.
